// File: rtl/serial_rx_sync_ctrl.sv
// Serial lane byte aligner: hunts for the comma at any bit offset, confirms
// lock over several aligned commas, then emits framed bytes at bit rate.
//
// Ports:
//   not_clk     bit clock, rising edge
//   reset       synchronous, active-high
//   data_in     serial bit, MSB first
//   resync      one-cycle request to drop lock and re-hunt
//   byte_out    aligned byte, 0x00 for commas and outside ACTIVE
//   byte_strobe one-cycle pulse per byte boundary while ACTIVE
//   valid_out   byte_out carries data, only with byte_strobe
//   active      lane locked
//   lock_state  00 SEARCH, 01 CONFIRM, 10 ACTIVE
//   loss_cnt    saturating count of ACTIVE->SEARCH drops
module serial_rx_sync_ctrl #(
  parameter logic [7:0]  COMMA        = 8'hBC,
  parameter int unsigned COMMA_LOCK   = 4,
  parameter int unsigned MISALIGN_MAX = 2
) (
  input  logic       not_clk,
  input  logic       reset,
  input  logic       data_in,
  input  logic       resync,
  output logic [7:0] byte_out,
  output logic       byte_strobe,
  output logic       valid_out,
  output logic       active,
  output logic [1:0] lock_state,
  output logic [7:0] loss_cnt
);

  localparam logic [3:0] LOCK_N = 4'(COMMA_LOCK);
  localparam logic [3:0] MIS_N  = 4'(MISALIGN_MAX);

  typedef enum logic [1:0] {
    SEARCH  = 2'b00,
    CONFIRM = 2'b01,
    ACTIVE  = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] window_q, window_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] comma_q, comma_d;
  logic [3:0] mis_q, mis_d;
  logic [7:0] byte_q, byte_d;
  logic       strobe_q, strobe_d;
  logic       valid_q, valid_d;
  logic [7:0] loss_q, loss_d;
  logic       match;
  logic       boundary;
  logic       drop;

  assign match    = (window_q == COMMA);
  assign boundary = (bit_cnt_q == 3'd0);

  always_comb begin
    window_d  = {window_q[6:0], data_in};
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    comma_d   = comma_q;
    mis_d     = mis_q;
    byte_d    = 8'h00;
    strobe_d  = 1'b0;
    valid_d   = 1'b0;
    loss_d    = loss_q;
    drop      = 1'b0;

    unique case (state_q)
      SEARCH: begin
        // The match cycle itself is boundary zero of the new grid.
        if (match) begin
          bit_cnt_d = 3'd1;
          comma_d   = 4'd1;
          state_d   = (LOCK_N == 4'd1) ? ACTIVE : CONFIRM;
        end
      end
      CONFIRM: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (resync) begin
          drop = 1'b1;
        end else if (boundary) begin
          if (match) begin
            comma_d = comma_q + 4'd1;
            if (comma_d == LOCK_N)
              state_d = ACTIVE;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          strobe_d = 1'b1;
          if (match) begin
            mis_d = 4'd0;
          end else begin
            valid_d = 1'b1;
            byte_d  = window_q;
          end
        end else if (match) begin
          mis_d = mis_q + 4'd1;
          if (mis_d == MIS_N)
            drop = 1'b1;
        end
        if (resync)
          drop = 1'b1;
      end
      default: begin
        state_d = SEARCH;
      end
    endcase

    // One drop per edge, whatever combination of causes.
    if (drop) begin
      if (state_q == ACTIVE && loss_q != 8'hFF)
        loss_d = loss_q + 8'd1;
      state_d   = SEARCH;
      bit_cnt_d = 3'd0;
      comma_d   = 4'd0;
      mis_d     = 4'd0;
      byte_d    = 8'h00;
      strobe_d  = 1'b0;
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge not_clk) begin
    if (reset) begin
      state_q   <= SEARCH;
      window_q  <= 8'h00;
      bit_cnt_q <= 3'd0;
      comma_q   <= 4'd0;
      mis_q     <= 4'd0;
      byte_q    <= 8'h00;
      strobe_q  <= 1'b0;
      valid_q   <= 1'b0;
      loss_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      window_q  <= window_d;
      bit_cnt_q <= bit_cnt_d;
      comma_q   <= comma_d;
      mis_q     <= mis_d;
      byte_q    <= byte_d;
      strobe_q  <= strobe_d;
      valid_q   <= valid_d;
      loss_q    <= loss_d;
    end
  end

  assign byte_out    = byte_q;
  assign byte_strobe = strobe_q;
  assign valid_out   = valid_q;
  assign active      = (state_q == ACTIVE);
  assign lock_state  = state_q;
  assign loss_cnt    = loss_q;

endmodule

// File: tb/tb_serial_rx_sync_ctrl.sv
// Bench for serial_rx_sync_ctrl: directed byte tables, hand sequences and a
// random stream, every cycle compared against a time-anchored lane model.
module tb_serial_rx_sync_ctrl;

  logic       not_clk;
  logic       reset;
  logic       data_in;
  logic       resync;
  logic [7:0] byte_out;
  logic       byte_strobe;
  logic       valid_out;
  logic       active;
  logic [1:0] lock_state;
  logic [7:0] loss_cnt;

  serial_rx_sync_ctrl dut (
    .not_clk    (not_clk),
    .reset      (reset),
    .data_in    (data_in),
    .resync     (resync),
    .byte_out   (byte_out),
    .byte_strobe(byte_strobe),
    .valid_out  (valid_out),
    .active     (active),
    .lock_state (lock_state),
    .loss_cnt   (loss_cnt)
  );

  initial begin
    not_clk = 1'b0;
    forever #5 not_clk = ~not_clk;
  end

  int total;
  int bad;

  // Lane model: bit history, absolute cycle time, boundary anchor time.
  bit   m_hist[$];
  int   m_t;
  int   m_anchor;
  int   m_mode;
  int   m_ncom;
  int   m_nmis;
  int   m_loss;
  logic [7:0] e_byte;
  bit   e_stb;
  bit   e_val;

  function automatic int hist_win();
    int w;
    w = 0;
    foreach (m_hist[i]) w = ((w << 1) | int'(m_hist[i])) & 255;
    return w;
  endfunction

  task automatic model_step(input bit d, input bit rs, input bit rst);
    int  w;
    bit  hit;
    bit  on_b;
    bit  lose;
    m_t++;
    if (rst) begin
      m_hist.delete();
      m_mode = 0; m_ncom = 0; m_nmis = 0; m_loss = 0;
      e_byte = 8'h00; e_stb = 0; e_val = 0;
      return;
    end
    w    = hist_win();
    hit  = (w == 188);
    on_b = (((m_t - m_anchor) % 8) == 0);
    lose = 0;
    e_byte = 8'h00; e_stb = 0; e_val = 0;
    case (m_mode)
      0: if (hit) begin
        m_anchor = m_t;
        m_ncom   = 1;
        m_mode   = 1;
      end
      1: begin
        if (rs) lose = 1;
        else if (on_b) begin
          if (hit) begin
            m_ncom++;
            if (m_ncom == 4) m_mode = 2;
          end else lose = 1;
        end
      end
      default: begin
        if (on_b) begin
          e_stb = 1;
          if (hit) m_nmis = 0;
          else begin
            e_val  = 1;
            e_byte = 8'(w);
          end
        end else if (hit) begin
          m_nmis++;
          if (m_nmis == 2) lose = 1;
        end
        if (rs) lose = 1;
      end
    endcase
    if (lose) begin
      if (m_mode == 2 && m_loss < 255) m_loss++;
      m_mode = 0; m_ncom = 0; m_nmis = 0;
      e_byte = 8'h00; e_stb = 0; e_val = 0;
    end
    m_hist.push_back(d);
    if (m_hist.size() > 8) void'(m_hist.pop_front());
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic logic [20:0] dut_vec();
    return {byte_out, byte_strobe, valid_out, active, lock_state, loss_cnt};
  endfunction

  task automatic tick(input bit d, input bit rs, input bit rst);
    logic [20:0] ex;
    data_in = d;
    resync  = rs;
    reset   = rst;
    @(posedge not_clk);
    model_step(d, rs, rst);
    #1;
    ex = {e_byte, e_stb, e_val, (m_mode == 2), 2'(m_mode), 8'(m_loss)};
    chk("model", 32'(dut_vec()), 32'(ex));
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int j = 7; j >= 0; j--) tick(b[j], 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       stb;
    logic       val;
    logic [7:0] bo;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [7:0] rb;
    int r;
    total = 0;
    bad   = 0;
    m_t = 0; m_anchor = 0; m_mode = 0; m_ncom = 0; m_nmis = 0; m_loss = 0;
    e_byte = 8'h00; e_stb = 0; e_val = 0;
    data_in = 1'b0; resync = 1'b0; reset = 1'b1;

    tbl[0] = '{8'hBC, 1'b0, 1'b0, 8'h00, 2'b01};
    tbl[1] = '{8'hBC, 1'b0, 1'b0, 8'h00, 2'b01};
    tbl[2] = '{8'hBC, 1'b0, 1'b0, 8'h00, 2'b01};
    tbl[3] = '{8'hBC, 1'b0, 1'b0, 8'h00, 2'b10};
    tbl[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 2'b10};
    tbl[5] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 2'b10};
    tbl[6] = '{8'h77, 1'b1, 1'b1, 8'h77, 2'b10};
    tbl[7] = '{8'hBC, 1'b1, 1'b0, 8'h00, 2'b10};
    tbl[8] = '{8'h78, 1'b1, 1'b1, 8'h78, 2'b10};

    // Reset state
    do_reset();
    chk("reset_outs", 32'(dut_vec()), 32'h0);

    // Lock on four commas, then data and an aligned idle comma.
    // Each byte's result shows on the edge after its last bit.
    for (int i = 0; i < 9; i++) begin
      for (int j = 7; j >= 0; j--) begin
        tick(tbl[i].tx[j], 1'b0, 1'b0);
        if (j == 7 && i > 0)
          chk($sformatf("tbl%0d", i - 1),
              32'({byte_strobe, valid_out, byte_out, lock_state}),
              32'({tbl[i-1].stb, tbl[i-1].val, tbl[i-1].bo, tbl[i-1].st}));
      end
    end
    tick(1'b0, 1'b0, 1'b0);
    chk("tbl8", 32'({byte_strobe, valid_out, byte_out, lock_state}),
        32'({tbl[8].stb, tbl[8].val, tbl[8].bo, tbl[8].st}));

    // Slip by 3 bits in total, two misaligned commas drop lock.
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    send_byte(8'hBC);
    chk("mis1_active", 32'(active), 32'd1);
    send_byte(8'hBC);
    tick(1'b0, 1'b0, 1'b0);
    chk("mis2_state", 32'(lock_state), 32'd0);
    chk("mis2_loss", 32'(loss_cnt), 32'd1);
    for (int k = 0; k < 4; k++) send_byte(8'hBC);
    tick(1'b0, 1'b0, 1'b0);
    chk("relock", 32'(lock_state), 32'd2);

    // Resync in ACTIVE
    tick(1'b0, 1'b1, 1'b0);
    chk("resync_state", 32'(lock_state), 32'd0);
    chk("resync_loss", 32'(loss_cnt), 32'd2);

    // Three commas then data: back to SEARCH, no loss counted.
    do_reset();
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    send_byte(8'h11);
    tick(1'b0, 1'b0, 1'b0);
    chk("nolock_state", 32'({active, lock_state}), 32'd0);
    chk("nolock_loss", 32'(loss_cnt), 32'd0);

    // Random prefix, comma at bit offset 5
    do_reset();
    for (int k = 0; k < 5; k++) tick(1'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(8'hBC);
    send_byte(8'hA5);
    tick(1'b0, 1'b0, 1'b0);
    chk("off5_byte", 32'({byte_strobe, valid_out, byte_out}), 32'h3A5);

    // Reset mid-byte clears everything
    tick(1'b0, 1'b1, 1'b0);
    chk("pre_rst_loss", 32'(loss_cnt), 32'd1);
    for (int k = 0; k < 4; k++) send_byte(8'hBC);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    chk("midbyte_rst", 32'(dut_vec()), 32'h0);

    // Random stream
    do_reset();
    for (int n = 0; n < 500; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45) send_byte(8'hBC);
      else if (r < 80) begin
        rb = 8'($urandom);
        send_byte(rb);
      end else if (r < 92) begin
        for (int k = 0; k < int'($urandom_range(1, 7)); k++)
          tick(1'($urandom), 1'b0, 1'b0);
      end else tick(1'($urandom), 1'b1, 1'b0);
    end

    // Loss counter saturation
    do_reset();
    for (int n = 0; n < 260; n++) begin
      for (int k = 0; k < 4; k++) send_byte(8'hBC);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
    end
    chk("loss_sat", 32'(loss_cnt), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
